// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 constants, uio bit map and GF(2^8) helpers
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    localparam int UIO_LD_KEY  = 0;
    localparam int UIO_LD_PT   = 1;
    localparam int UIO_START   = 2;
    localparam int UIO_RD_NEXT = 3;
    localparam int UIO_IV_CLR  = 4;
    localparam int UIO_BUSY    = 4;
    localparam int UIO_DONE    = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_t;

    // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product by shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Round constant for rounds 1..10; other indices never reach the key schedule.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // MixColumns on one column, byte 0 in the top bits.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES S-box from GF(2^8) inverse and affine map
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // Inverse as din^254 via an addition chain (0 maps to 0), then the affine transform.
    always_comb begin
        x2   = gf_mul(din, din);
        x3   = gf_mul(x2, din);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        dout = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    end

endmodule

// File: rtl/aes_encrypt.sv
// rtl/aes_encrypt.sv - iterative AES-128 encryptor tile top; AES_CBC_CHAIN_EN adds CBC chaining
module aes_encrypt
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [127:0] key_q, pt_q, state_q, rk_q, ct_q;
    logic [3:0]   round_q;
    logic [3:0]   ptr_q;
    logic         done_q;
    fsm_t         fsm_q, fsm_d;

    logic ld_key, ld_pt, start, rd_next, busy;
    assign ld_key  = uio_in[UIO_LD_KEY];
    assign ld_pt   = uio_in[UIO_LD_PT];
    assign start   = uio_in[UIO_START];
    assign rd_next = uio_in[UIO_RD_NEXT];
    assign busy    = (fsm_q == ST_RUN);

`ifdef AES_CBC_CHAIN_EN
    logic [127:0] chain_q;
    logic         iv_clr;
    logic         unused_bits;
    assign iv_clr      = uio_in[UIO_IV_CLR];
    assign unused_bits = ^uio_in[7:5];
`else
    logic         unused_bits;
    assign unused_bits = ^uio_in[7:4];
`endif

    // ---------------- key schedule: next round key from rk_q ----------------
    logic [31:0]  w3_rot, ks_sub, ks_temp;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic [127:0] next_rk;

    assign w3_rot = {rk_q[23:0], rk_q[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ks_sbox
            aes_sbox u_ks_sbox (
                .din  (w3_rot[31-8*gi -: 8]),
                .dout (ks_sub[31-8*gi -: 8])
            );
        end
    endgenerate

    assign ks_temp = ks_sub ^ {rcon(round_q), 24'h000000};
    assign nw0     = rk_q[127:96] ^ ks_temp;
    assign nw1     = rk_q[95:64]  ^ nw0;
    assign nw2     = rk_q[63:32]  ^ nw1;
    assign nw3     = rk_q[31:0]   ^ nw2;
    assign next_rk = {nw0, nw1, nw2, nw3};

    // ---------------- round function ----------------
    logic [127:0] sb_flat, sr_flat, mc_flat, round_out;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_state_sbox
            aes_sbox u_sbox (
                .din  (state_q[127-8*gi -: 8]),
                .dout (sb_flat[127-8*gi -: 8])
            );
        end
        for (gi = 0; gi < 4; gi++) begin : g_mix
            assign mc_flat[127-32*gi -: 32] = mix_column(sr_flat[127-32*gi -: 32]);
        end
    endgenerate

    // ShiftRows: row r of column c takes row r of column (c + r) mod 4; byte index is r + 4c.
    always_comb begin
        sr_flat = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_flat[127-8*(r+4*c) -: 8] = sb_flat[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
    end

    assign round_out = ((round_q == NR) ? sr_flat : mc_flat) ^ next_rk;

    // ---------------- control ----------------
    // Next-state logic: idle until start, run until the final round has been applied.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: if (ena && start) fsm_d = ST_RUN;
            ST_RUN:  if (ena && (round_q == NR)) fsm_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) fsm_q <= ST_IDLE;
        else     fsm_q <= fsm_d;
    end

    // Datapath registers: loads and reads while idle, one round per edge while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q   <= '0;
            pt_q    <= '0;
            state_q <= '0;
            rk_q    <= '0;
            ct_q    <= '0;
            round_q <= 4'd0;
            ptr_q   <= 4'd0;
            done_q  <= 1'b0;
`ifdef AES_CBC_CHAIN_EN
            chain_q <= '0;
`endif
        end else if (ena) begin
            if (fsm_q == ST_IDLE) begin
                if (start) begin
`ifdef AES_CBC_CHAIN_EN
                    state_q <= pt_q ^ chain_q ^ key_q;
`else
                    state_q <= pt_q ^ key_q;
`endif
                    rk_q    <= key_q;
                    round_q <= 4'd1;
                    done_q  <= 1'b0;
                end else begin
                    if (ld_key)          key_q  <= {key_q[119:0], ui_in};
                    if (ld_pt)           pt_q   <= {pt_q[119:0], ui_in};
                    if (ld_key || ld_pt) done_q <= 1'b0;
                    if (rd_next && done_q) ptr_q <= ptr_q + 4'd1;
`ifdef AES_CBC_CHAIN_EN
                    if (iv_clr)          chain_q <= '0;
`endif
                end
            end else begin
                state_q <= round_out;
                rk_q    <= next_rk;
                round_q <= round_q + 4'd1;
                if (round_q == NR) begin
                    ct_q   <= round_out;
                    done_q <= 1'b1;
                    ptr_q  <= 4'd0;
`ifdef AES_CBC_CHAIN_EN
                    chain_q <= round_out;
`endif
                end
            end
        end
    end

    // ---------------- outputs ----------------
    logic [6:0] rd_lsb;
    assign rd_lsb  = {~ptr_q, 3'b000};
    assign uo_out  = done_q ? ct_q[rd_lsb +: 8] : 8'h00;
    assign uio_out = {2'b00, done_q, busy, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_aes_encrypt.sv
// tb/tb_aes_encrypt.sv - directed-vector bench for aes_encrypt
module tb_aes_encrypt;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    aes_encrypt dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs[3];
    int   tests = 0;
    int   fails = 0;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int idx, input logic [7:0] b);
        uio_in      = 8'h00;
        uio_in[idx] = 1'b1;
        ui_in       = b;
        tick();
        uio_in = 8'h00;
        ui_in  = 8'h00;
    endtask

    task automatic load_block(input int idx, input logic [127:0] d);
        for (int i = 0; i < 16; i++) pulse(idx, d[127-8*i -: 8]);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!uio_out[UIO_DONE] && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Returns number of edges from the start edge to done high.
    task automatic start_run(input bit clr, output int lat);
        int n;
        if (clr) pulse(UIO_IV_CLR, 8'h00);
        pulse(UIO_START, 8'h00);
        wait_done(n);
        lat = n + 1;
    endtask

    task automatic read_ct(output logic [127:0] got);
        for (int i = 0; i < 16; i++) begin
            got[127-8*i -: 8] = uo_out;
            pulse(UIO_RD_NEXT, 8'h00);
        end
    endtask

    initial begin
        logic [127:0] got;
        int           lat;
        int           n;

        vecs[0] = '{key: KEY_B, pt: PT_B, ct: CT_B};
        vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    pt:  128'h00112233445566778899aabbccddeeff,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{key: 128'h0, pt: 128'h0, ct: CT_0};

        rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        tick(); tick();
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'hF0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 3; v++) begin
            load_block(UIO_LD_KEY, vecs[v].key);
            load_block(UIO_LD_PT, vecs[v].pt);
            start_run(1'b1, lat);
            check($sformatf("latency_v%0d", v), lat, 11);
            read_ct(got);
            check($sformatf("ct_v%0d", v), got, vecs[v].ct);
            if (v == 2) begin
                check("wrap_byte0", uo_out, 8'h66);
                pulse(UIO_RD_NEXT, 8'h00);
                check("wrap_byte1", uo_out, 8'he9);
            end
        end

        // Start and ld_pt strobes during a run are ignored.
        load_block(UIO_LD_KEY, KEY_B);
        load_block(UIO_LD_PT, PT_B);
        pulse(UIO_IV_CLR, 8'h00);
        pulse(UIO_START, 8'h00);
        tick(); tick();
        uio_in = 8'h00;
        uio_in[UIO_START] = 1'b1;
        uio_in[UIO_LD_PT] = 1'b1;
        ui_in = 8'hAA;
        tick(); tick();
        check("busy_during_strobes", uio_out[UIO_BUSY], 1'b1);
        uio_in = 8'h00; ui_in = 8'h00;
        wait_done(n);
        read_ct(got);
        check("ct_busy_ignore", got, CT_B);
        start_run(1'b1, lat);
        read_ct(got);
        check("ct_pt_unchanged", got, CT_B);

        // ena low: strobes ignored, state held.
        ena = 1'b0;
        pulse(UIO_LD_KEY, 8'h55);
        pulse(UIO_RD_NEXT, 8'h00);
        pulse(UIO_START, 8'h00);
        check("ena0_done_held", uio_out, 8'h20);
        check("ena0_ptr_held", uo_out, 8'h39);
        ena = 1'b1;
        start_run(1'b1, lat);
        read_ct(got);
        check("ct_after_ena0", got, CT_B);

        // A load clears done.
        pulse(UIO_LD_PT, 8'h00);
        check("load_clears_done", uio_out, 8'h00);
        check("load_clears_uo", uo_out, 8'h00);

        // Reset in the middle of a run.
        pulse(UIO_START, 8'h00);
        for (int i = 0; i < 5; i++) tick();
        check("busy_mid_run", uio_out[UIO_BUSY], 1'b1);
        rst = 1'b1;
        tick();
        check("rst_mid_uio_out", uio_out, 8'h00);
        check("rst_mid_uo_out", uo_out, 8'h00);
        rst = 1'b0;
        start_run(1'b1, lat);
        check("latency_after_rst", lat, 11);
        read_ct(got);
        check("ct_after_rst", got, CT_0);

`ifdef AES_CBC_CHAIN_EN
        start_run(1'b0, lat);
        read_ct(got);
        check("cbc_second_block", got, 128'hf795bd4a52e29ed713d313fa20e98dbc);
        start_run(1'b1, lat);
        read_ct(got);
        check("cbc_after_iv_clr", got, CT_0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
